// File: rtl/lsu_ram_if.sv
// lsu_ram_if -- request/response bus between the load/store stage and lsu_ram.
//   master : drives req_* and resp_ready (the hart side)
//   slave  : drives req_ready and resp_* (the memory side)
// Signals:
//   req_valid/req_ready    request handshake
//   req_write              1 = store, 0 = load
//   req_addr[XLEN]         byte address
//   req_width[2]           00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned           zero-extend loads when 1
//   req_wdata[XLEN]        right-aligned store data
//   resp_valid/resp_ready  response handshake
//   resp_rdata[XLEN]       extended load result (0 for stores/errors)
//   resp_error             access rejected
interface lsu_ram_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_width;
  logic            req_unsigned;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_width, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_width, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/lsu_ram.sv
// lsu_ram -- parametrised data memory with request/response handshake.
// One request outstanding at a time. Loads are sign/zero-extended, bad
// accesses report resp_error, and the response is held under backpressure.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset (memory contents are not reset)
//   bus    lsu_ram_if.slave (request/response handshake, see interface)
//
// Parameters:
//   XLEN          data/address width, must be 32
//   DEPTH_WORDS   number of words, power of two 4..65536
//   READ_LATENCY  edges from acceptance to resp_valid, 1..4
//
// Optional feature macro: LSU_RAM_ALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses are errors
//   undefined : offset is forced to natural alignment, no misalignment error
module lsu_ram #(
  parameter int XLEN         = 32,
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 1
) (
  input logic       clock,
  input logic       reset,
  lsu_ram_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam int CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            error_q, error_d;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  // ---------------------------------------------------------------------
  // Request decode (combinational, only meaningful on the acceptance edge)
  // ---------------------------------------------------------------------
  logic            accept;
  logic [AW-1:0]   idx;
  logic            oob;
  logic [1:0]      off;
  logic            misalign;
  logic            bad;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rd_sh;
  logic [XLEN-1:0] load_val;

  assign accept = bus.req_valid && (state_q == S_IDLE);
  assign idx    = bus.req_addr[AW+1:2];
  // Any bit above the word index set means the address is past the array.
  assign oob    = |bus.req_addr[XLEN-1:AW+2];

  always_comb begin
    off      = bus.req_addr[1:0];
    misalign = 1'b0;
    case (bus.req_width)
`ifdef LSU_RAM_ALIGN_CHECK_EN
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = |bus.req_addr[1:0];
`else
      // Without the check, drop the low address bits so the access lands
      // on its natural boundary instead of straddling words.
      2'b01:   off = {bus.req_addr[1], 1'b0};
      2'b10:   off = 2'b00;
`endif
      default: ;
    endcase
  end

  assign bad = (bus.req_width == 2'b11) || oob || misalign;

  always_comb begin
    case (bus.req_width)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
  end

  assign wdata_sh = bus.req_wdata << {off, 3'b000};
  assign rd_sh    = mem_q[idx] >> {off, 3'b000};

  always_comb begin
    case (bus.req_width)
      2'b00:   load_val = bus.req_unsigned ? {24'h0, rd_sh[7:0]}
                                           : {{24{rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   load_val = bus.req_unsigned ? {16'h0, rd_sh[15:0]}
                                           : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: load_val = rd_sh;
    endcase
  end

  // ---------------------------------------------------------------------
  // Storage: written on the acceptance edge, never reset
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset && accept && bus.req_write && !bad) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Result is fully formed at acceptance, so later req_* changes
          // cannot disturb the pending response.
          error_d = bad;
          rdata_d = (bad || bus.req_write) ? '0 : load_val;
          if (READ_LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(READ_LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;
endmodule

// File: tb/tb_lsu_ram.sv
module tb_lsu_ram;
  localparam int DEPTH = 256;
  localparam int BYTES = 4 * DEPTH;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lsu_ram_if #(.XLEN(32)) if1 ();
  lsu_ram_if #(.XLEN(32)) if3 ();

  logic        t_valid, t_sel, t_write, t_uns, t_rready;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  t_width;

  assign if1.req_valid    = t_valid & ~t_sel;
  assign if3.req_valid    = t_valid & t_sel;
  assign if1.req_write    = t_write;
  assign if3.req_write    = t_write;
  assign if1.req_addr     = t_addr;
  assign if3.req_addr     = t_addr;
  assign if1.req_width    = t_width;
  assign if3.req_width    = t_width;
  assign if1.req_unsigned = t_uns;
  assign if3.req_unsigned = t_uns;
  assign if1.req_wdata    = t_wdata;
  assign if3.req_wdata    = t_wdata;
  assign if1.resp_ready   = t_rready;
  assign if3.resp_ready   = t_rready;

  lsu_ram #(.XLEN(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .bus(if1));
  lsu_ram #(.XLEN(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset), .bus(if3));

  int checks = 0;
  int errors = 0;

  // Reference memory: one byte array per DUT instance.
  logic [7:0] mm [2][BYTES];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [1:0]  wd;
    bit          u;
    logic [31:0] d;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl [13];

  function automatic logic rv(input bit s);
    return s ? if3.resp_valid : if1.resp_valid;
  endfunction
  function automatic logic rr(input bit s);
    return s ? if3.req_ready : if1.req_ready;
  endfunction
  function automatic logic [31:0] rd(input bit s);
    return s ? if3.resp_rdata : if1.resp_rdata;
  endfunction
  function automatic logic re(input bit s);
    return s ? if3.resp_error : if1.resp_error;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Behavioural model: byte-addressed array, access of 1<<width bytes.
  function automatic void model(input int s, input bit w, input logic [31:0] a,
                                input logic [1:0] wd, input bit u, input logic [31:0] d,
                                output logic [31:0] r, output bit e);
    int n;
    logic [31:0] base;
    e = 1'b0;
    r = 32'h0;
    n = 1 << wd;
    if (wd == 2'd3 || a >= 32'(BYTES)) e = 1'b1;
    base = a;
    if (!e) begin
`ifdef LSU_RAM_ALIGN_CHECK_EN
      if ((a & 32'(n - 1)) != 0) e = 1'b1;
`else
      base = a - (a & 32'(n - 1));
`endif
    end
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mm[s][base + 32'(i)] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) r[8*i +: 8] = mm[s][base + 32'(i)];
        if (!u && n < 4 && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8*n));
      end
    end
  endfunction

  task automatic issue(input bit s, input bit w, input logic [31:0] a,
                       input logic [1:0] wd, input bit u, input logic [31:0] d);
    int g = 0;
    while (!rr(s) && g < 20) begin
      @(posedge clock); #1;
      g++;
    end
    if (!rr(s)) chk("req_ready_timeout", 32'(rr(s)), 32'd1);
    t_sel = s; t_write = w; t_addr = a; t_width = wd; t_uns = u; t_wdata = d;
    t_valid = 1'b1;
    @(posedge clock); #1;
    t_valid = 1'b0;
    // Scramble fields: the pending response must not depend on them.
    t_addr = $urandom; t_width = 2'($urandom); t_uns = 1'($urandom); t_wdata = $urandom;
  endtask

  task automatic wait_resp(input bit s);
    int lat = 1;
    while (!rv(s) && lat < 20) begin
      chk("req_ready_in_wait", 32'(rr(s)), 32'd0);
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", 32'(lat), s ? 32'd3 : 32'd1);
  endtask

  task automatic take_resp();
    t_rready = 1'b1;
    @(posedge clock); #1;
    t_rready = 1'b0;
  endtask

  task automatic do_txn(input bit s, input bit w, input logic [31:0] a,
                        input logic [1:0] wd, input bit u, input logic [31:0] d,
                        input logic [31:0] er, input bit ee, input int stall);
    issue(s, w, a, wd, u, d);
    wait_resp(s);
    for (int c = 0; c < stall; c++) begin
      @(posedge clock); #1;
    end
    chk("rdata", rd(s), er);
    chk("error", 32'(re(s)), 32'(ee));
    take_resp();
  endtask

  initial begin
    logic [31:0] r, dat;
    bit e;
    logic [31:0] a;
    logic [1:0] wd;
    bit s, w, u;
    int sel;

    tbl[0]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'h8765_4321, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h8765_4321, 1'b0};
    tbl[2]  = '{1'b1, 32'h12, 2'd1, 1'b0, 32'h0000_FEDC, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h11, 2'd0, 1'b0, 32'h0000_00BA, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hFEDC_BA21, 1'b0};
    tbl[5]  = '{1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b0};
    tbl[6]  = '{1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 32'h0000_FEDC, 1'b0};
    tbl[7]  = '{1'b0, 32'h20, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[8]  = '{1'b1, 32'(BYTES), 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1};
    tbl[9]  = '{1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'hC0DE_0000, 1'b0};
`ifdef LSU_RAM_ALIGN_CHECK_EN
    tbl[10] = '{1'b0, 32'h11, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1};
`else
    tbl[10] = '{1'b0, 32'h11, 2'd2, 1'b0, 32'h0, 32'hFEDC_BA21, 1'b0};
`endif
    tbl[11] = '{1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 32'hFFFF_FEDC, 1'b0};
    tbl[12] = '{1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 32'h0000_00BA, 1'b0};

    t_valid = 0; t_sel = 0; t_write = 0; t_uns = 0; t_rready = 0;
    t_addr = 0; t_wdata = 0; t_width = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_req_ready", 32'(rr(i[0])), 32'd1);
      chk("reset_resp_valid", 32'(rv(i[0])), 32'd0);
      chk("reset_rdata", rd(i[0]), 32'd0);
      chk("reset_error", 32'(re(i[0])), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;

    // Fill both memories with a known pattern so the model is fully defined.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        dat = 32'hC0DE_0000 ^ (32'(k) * 32'h0101_0101);
        model(i, 1'b1, 32'(4 * k), 2'd2, 1'b0, dat, r, e);
        do_txn(i[0], 1'b1, 32'(4 * k), 2'd2, 1'b0, dat, r, e, 0);
      end
    end

    // Directed table on both latencies.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 13; k++) begin
        model(i, tbl[k].w, tbl[k].a, tbl[k].wd, tbl[k].u, tbl[k].d, r, e);
        do_txn(i[0], tbl[k].w, tbl[k].a, tbl[k].wd, tbl[k].u, tbl[k].d,
               tbl[k].er, tbl[k].ee, 0);
      end
    end

    // Backpressure: response held 5 cycles, stray request ignored.
    issue(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    wait_resp(1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_resp_valid", 32'(rv(1'b0)), 32'd1);
      chk("bp_rdata", rd(1'b0), 32'hFEDC_BA21);
      chk("bp_req_ready", 32'(rr(1'b0)), 32'd0);
      if (c == 2) begin
        t_sel = 1'b0; t_write = 1'b1; t_addr = 32'h10; t_width = 2'd2; t_wdata = 32'h0;
        t_valid = 1'b1;
      end
      @(posedge clock); #1;
      t_valid = 1'b0;
    end
    take_resp();
    chk("bp_idle_after", 32'(rv(1'b0)), 32'd0);
    do_txn(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hFEDC_BA21, 1'b0, 0);

    // Reset while a load sits in WAIT on the latency-3 instance.
    model(1, 1'b1, 32'h40, 2'd2, 1'b0, 32'h1122_3344, r, e);
    do_txn(1'b1, 1'b1, 32'h40, 2'd2, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 0);
    issue(1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
    @(posedge clock); #1;
    chk("mid_in_wait", 32'(rr(1'b1)), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 32'(rv(1'b1)), 32'd0);
    chk("mid_rst_req_ready", 32'(rr(1'b1)), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_req_ready", 32'(rr(1'b1)), 32'd1);
    chk("post_rst_resp_valid", 32'(rv(1'b1)), 32'd0);
    do_txn(1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h1122_3344, 1'b0, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 1);
      s   = sel[0];
      w   = 1'($urandom);
      u   = 1'($urandom);
      wd  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 15))
        0:       a = 32'(BYTES) + 32'($urandom_range(0, 4095));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, BYTES - 1));
      endcase
      dat = $urandom;
      model(sel, w, a, wd, u, dat, r, e);
      do_txn(s, w, a, wd, u, dat, r, e, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ram.md
Name: lsu_ram

Overview:
- Parametrised data memory with a request/response handshake; successor to the single-port byte-enable RAM wrapper.
- Adds configurable depth and read latency, sign/zero-extending loads, error reporting for bad accesses, and response backpressure.
- Sits between the hart's load/store stage and on-chip storage; one outstanding request at a time.

Parameters:
- XLEN, 32, data/address width in bits; must be 32.
- DEPTH_WORDS, 256, number of XLEN-bit words; power of two, 4..65536.
- READ_LATENCY, 1, cycles from acceptance edge to resp_valid; 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address.
- req_width  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for word accesses and stores.
- req_wdata  in  XLEN  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  XLEN  load result, extended to XLEN; 0 for stores and errors.
- resp_error  out  1  access rejected.

Behaviour:
- Reset state (asynchronous):
  - FSM = IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0; latency counter = 0.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE).
  - resp_valid = (state==RESP).
- Transitions:
  - IDLE: on req_valid&&req_ready, go to RESP if READ_LATENCY==1, else to WAIT with counter=READ_LATENCY-1.
  - WAIT: decrement the counter each cycle; when it reaches 1, go to RESP on the next edge.
  - RESP: hold resp_* stable until resp_ready=1, then go to IDLE. A request can be accepted no earlier than the cycle after the handshake.
- Acceptance and timing:
  - A request is accepted on the edge where req_valid&&req_ready.
  - resp_valid rises exactly READ_LATENCY edges after acceptance.
- Address decode:
  - word index = req_addr[$clog2(DEPTH_WORDS)+1:2]; byte offset = req_addr[1:0].
- Errors (resp_error=1, resp_rdata=0, no memory write):
  - req_width==11.
  - req_addr >= 4*DEPTH_WORDS (out of range; upper bits checked).
  - Misaligned access, only when the optional feature is enabled.
- Stores:
  - Memory is written on the acceptance edge.
  - Byte enables: byte = 0001<<offset; half = 0011<<offset; word = 1111.
  - Write data is shifted left by offset*8.
  - Unenabled bytes are unchanged.
- Loads:
  - The word is read on the acceptance edge and held in a pipeline register through WAIT/RESP.
  - The result is shifted right by offset*8, masked to the access width, then sign- or zero-extended per req_unsigned.
  - Request fields are captured at acceptance; later changes to req_* have no effect on the pending response.
- Reset mid-operation:
  - A store accepted before reset remains committed.
  - A pending load response is discarded; the FSM returns to IDLE.
- Inputs are ignored while req_ready=0. No hazards arise, since only one request is outstanding.

Optional Feature:
- Macro: LSU_RAM_ALIGN_CHECK_EN.
- Defined:
  - Halfword with req_addr[0]=1 is an error.
  - Word with req_addr[1:0]!=0 is an error.
  - Errored accesses do not write and return resp_error=1, resp_rdata=0.
- Undefined:
  - No misalignment errors.
  - Offset is forced to natural alignment: halfword uses {addr[1],1'b0}; word uses 00.
  - The access proceeds normally; only width==11 and out-of-range accesses report errors.

Test Plan:
- Word round trip (READ_LATENCY=1):
  - Store word 0x87654321 at 0x10, then load word at 0x10.
  - Expect resp_valid exactly 1 edge after acceptance, rdata=0x87654321, error=0.
- Sub-word stores:
  - Store half 0xFEDC at 0x12, then byte 0xBA at 0x11.
  - Load word at 0x10 → 0xFEDCBA21.
  - Load signed byte at 0x13 → 0xFFFFFFFE; unsigned half at 0x12 → 0x0000FEDC.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles after a load.
  - resp_valid and rdata remain stable; req_ready stays 0; a req_valid pulse during the stall is not accepted.
- Errors:
  - Width 11 at 0x20 → error=1, rdata=0.
  - Store to 4*DEPTH_WORDS → error=1, and a following load of word 0 is unchanged.
  - With LSU_RAM_ALIGN_CHECK_EN: word load at 0x11 → error=1.
  - Without it: word load at 0x11 returns the word at 0x10.
- Latency:
  - READ_LATENCY=3: resp_valid asserts exactly 3 edges after acceptance; req_ready is low during WAIT.
- Reset mid-operation:
  - Store 0x11223344 at 0x40, then a load at 0x40, and assert reset during WAIT.
  - resp_valid drops immediately and req_ready=1 after release.
  - A re-issued load returns 0x11223344.
